// File: rtl/calc_result_formatter_if.sv
// rtl/calc_result_formatter_if.sv - issue/result handshake bundle for calc_result_formatter
interface calc_result_formatter_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [7:0] A;
  logic [7:0] B;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       ovf;
  logic       dbz;

  // Issuer / consumer side
  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, result, ovf, dbz
  );

  // Formatter side
  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, result, ovf, dbz
  );
endinterface

// File: rtl/calc_result_formatter.sv
// rtl/calc_result_formatter.sv - selects, rounds and saturates arithmetic unit results to Q(7-FRAC).FRAC; sticky flags under FMT_STICKY_EN
module calc_result_formatter #(
  parameter int FRAC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  calc_result_formatter_if.slave bus,
  input  logic [7:0]            sum_in,
  input  logic [7:0]            sub_in,
  input  logic [15:0]           prod_in,
  input  logic [7:0]            div_in,
  output logic                  ovf_sticky,
  output logic                  dbz_sticky,
  input  logic                  clr_sticky
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FMT  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  // Largest integer quotient magnitude representable once scaled by 2^FRAC
  localparam int QLIM = 1 << (7 - FRAC);
  // Rounding constant for the Q(2*FRAC) product (round half up)
  localparam int HALF = 1 << (FRAC - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] raw_q, raw_d;
  logic [7:0]  result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        dbz_q, dbz_d;
  logic        out_valid_q, out_valid_d;

  logic [7:0]         fmt_result;
  logic               fmt_ovf;
  logic               fmt_dbz;
  logic signed [16:0] mul_rnd;
  logic signed [16:0] mul_sh;
  int                 div_q;

  // Format the captured raw result according to the captured operation
  always_comb begin
    fmt_result = raw_q[7:0];
    fmt_ovf    = 1'b0;
    fmt_dbz    = 1'b0;
    mul_rnd    = $signed({raw_q[15], raw_q}) + 17'(HALF);
    mul_sh     = mul_rnd >>> FRAC;
    div_q      = int'($signed(raw_q[7:0]));
    case (op_q)
      OP_ADD: begin
        // Same-sign operands producing a sign flip means the true sum left the range
        if ((a_q[7] == b_q[7]) && (raw_q[7] != a_q[7])) begin
          fmt_ovf    = 1'b1;
          fmt_result = a_q[7] ? 8'h80 : 8'h7F;
        end
      end
      OP_SUB: begin
        if ((a_q[7] != b_q[7]) && (raw_q[7] != a_q[7])) begin
          fmt_ovf    = 1'b1;
          fmt_result = a_q[7] ? 8'h80 : 8'h7F;
        end
      end
      OP_MUL: begin
        if (mul_sh > 17'sd127) begin
          fmt_ovf    = 1'b1;
          fmt_result = 8'h7F;
        end else if (mul_sh < -17'sd128) begin
          fmt_ovf    = 1'b1;
          fmt_result = 8'h80;
        end else begin
          fmt_result = mul_sh[7:0];
        end
      end
      default: begin
        // Divide: zero divisor first, then the one quotient the unit cannot represent
        if (b_q == 8'h00) begin
          fmt_dbz    = 1'b1;
          fmt_result = a_q[7] ? 8'h80 : 8'h7F;
        end else if ((a_q == 8'h80) && (b_q == 8'hFF)) begin
          fmt_ovf    = 1'b1;
          fmt_result = 8'h7F;
        end else if (div_q > (QLIM - 1)) begin
          fmt_ovf    = 1'b1;
          fmt_result = 8'h7F;
        end else if (div_q < -QLIM) begin
          fmt_ovf    = 1'b1;
          fmt_result = 8'h80;
        end else begin
          fmt_result = raw_q[7:0] << FRAC;
        end
      end
    endcase
  end

  // Sequencer: capture operands, capture raw result a cycle later, format, then hold until consumed
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    raw_d       = raw_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          a_d     = bus.A;
          b_d     = bus.B;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The unit registered its outputs on the capture edge; they are valid now
        case (op_q)
          OP_ADD:  raw_d = {8'h00, sum_in};
          OP_SUB:  raw_d = {8'h00, sub_in};
          OP_MUL:  raw_d = prod_in;
          default: raw_d = {8'h00, div_in};
        endcase
        state_d = ST_FMT;
      end
      ST_FMT: begin
        result_d    = fmt_result;
        ovf_d       = fmt_ovf;
        dbz_d       = fmt_dbz;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      default: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'd0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      raw_q       <= 16'h0000;
      result_q    <= 8'h00;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      raw_q       <= raw_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbz       = dbz_q;

`ifdef FMT_STICKY_EN
  logic ovf_sticky_q, ovf_sticky_d;
  logic dbz_sticky_q, dbz_sticky_d;

  // Sticky flags: clear request first so a same-edge set overrides it
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    dbz_sticky_d = dbz_sticky_q;
    if (clr_sticky) begin
      ovf_sticky_d = 1'b0;
      dbz_sticky_d = 1'b0;
    end
    if (state_q == ST_FMT) begin
      if (fmt_ovf) ovf_sticky_d = 1'b1;
      if (fmt_dbz) dbz_sticky_d = 1'b1;
    end
  end

  // Sticky flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_sticky_q <= 1'b0;
      dbz_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      dbz_sticky_q <= dbz_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
  assign dbz_sticky = dbz_sticky_q;
`else
  logic unused_clr_sticky;

  assign unused_clr_sticky = clr_sticky;
  assign ovf_sticky        = 1'b0;
  assign dbz_sticky        = 1'b0;
`endif

endmodule

// File: tb/tb_calc_result_formatter.sv
// tb/tb_calc_result_formatter.sv - randomized self-checking bench for calc_result_formatter
module tb_calc_result_formatter;
  localparam int FRAC = 4;

  logic        clk;
  logic        rst;
  logic [7:0]  sum_in;
  logic [7:0]  sub_in;
  logic [15:0] prod_in;
  logic [7:0]  div_in;
  logic        ovf_sticky;
  logic        dbz_sticky;
  logic        clr_sticky;

  calc_result_formatter_if bus();

  calc_result_formatter #(.FRAC(FRAC)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sum_in     (sum_in),
    .sub_in     (sub_in),
    .prod_in    (prod_in),
    .div_in     (div_in),
    .ovf_sticky (ovf_sticky),
    .dbz_sticky (dbz_sticky),
    .clr_sticky (clr_sticky)
  );

  int checks = 0;
  int errors = 0;
  logic sticky_ovf_m = 1'b0;
  logic sticky_dbz_m = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ideal result: exact arithmetic, then clamp to the 8-bit Q range
  task automatic model(input logic [1:0] op_v, input logic [7:0] a_v, input logic [7:0] b_v,
                       output logic [7:0] r, output logic o, output logic d);
    int  sa, sb, v;
    real x;
    sa = int'($signed(a_v));
    sb = int'($signed(b_v));
    o  = 1'b0;
    d  = 1'b0;
    v  = 0;
    case (op_v)
      2'd0: v = sa + sb;
      2'd1: v = sa - sb;
      2'd2: begin
        x = $floor(real'(sa * sb) / real'(2 ** FRAC) + 0.5);
        v = int'(x);
      end
      default: begin
        if (sb == 0) d = 1'b1;
        else v = (sa / sb) * (2 ** FRAC);
      end
    endcase
    if (d) begin
      r = (sa < 0) ? 8'h80 : 8'h7F;
    end else if (v > 127) begin
      r = 8'h7F; o = 1'b1;
    end else if (v < -128) begin
      r = 8'h80; o = 1'b1;
    end else begin
      r = v[7:0];
    end
  endtask

  // Arithmetic unit outputs as they appear one edge after the operands
  task automatic drive_unit(input logic [7:0] a_v, input logic [7:0] b_v);
    int sa, sb, p;
    sa = int'($signed(a_v));
    sb = int'($signed(b_v));
    p  = sa * sb;
    sum_in  = a_v + b_v;
    sub_in  = a_v - b_v;
    prod_in = p[15:0];
    if (sb == 0) div_in = 8'($urandom);
    else div_in = 8'(sa / sb);
  endtask

  task automatic check_sticky(input string tag);
    check({tag, "_ovf_sticky"}, {31'd0, ovf_sticky}, {31'd0, sticky_ovf_m});
    check({tag, "_dbz_sticky"}, {31'd0, dbz_sticky}, {31'd0, sticky_dbz_m});
  endtask

  task automatic run_op(input logic [1:0] op_v, input logic [7:0] a_v, input logic [7:0] b_v, input int stall);
    logic [7:0] er;
    logic       eo, ed;
    model(op_v, a_v, b_v, er, eo, ed);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = op_v;
    bus.A  = a_v;
    bus.B  = b_v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drive_unit(a_v, b_v);
    bus.A  = 8'($urandom);
    bus.B  = 8'($urandom);
    bus.op = 2'($urandom);
    check("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    check("early_out_valid", {31'd0, bus.out_valid}, 32'd0);
    sum_in  = 8'($urandom);
    sub_in  = 8'($urandom);
    prod_in = 16'($urandom);
    div_in  = 8'($urandom);
`ifdef FMT_STICKY_EN
    sticky_ovf_m = sticky_ovf_m | eo;
    sticky_dbz_m = sticky_dbz_m | ed;
`endif
    @(posedge clk); #1;
    check("out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("result", {24'd0, bus.result}, {24'd0, er});
    check("ovf", {31'd0, bus.ovf}, {31'd0, eo});
    check("dbz", {31'd0, bus.dbz}, {31'd0, ed});
    check_sticky("fmt");
    for (int i = 0; i < stall; i++) begin
      if (i == 1) bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_result", {24'd0, bus.result}, {24'd0, er});
      check("hold_ovf", {31'd0, bus.ovf}, {31'd0, eo});
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("done_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("done_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
`ifdef FMT_STICKY_EN
    sticky_ovf_m = 1'b0;
    sticky_dbz_m = 1'b0;
`endif
    check_sticky("clr");
  endtask

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = 2'd0;
    bus.A = 8'h00;
    bus.B = 8'h00;
    bus.out_ready = 1'b0;
    clr_sticky = 1'b0;
    sum_in = 8'h00;
    sub_in = 8'h00;
    prod_in = 16'h0000;
    div_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", {24'd0, bus.result}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    check("rst_dbz", {31'd0, bus.dbz}, 32'd0);
    check_sticky("rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    run_op(2'd0, 8'h30, 8'h20, 0);
    run_op(2'd1, 8'h80, 8'h10, 0);
    run_op(2'd2, 8'h18, 8'h28, 0);
    run_op(2'd2, 8'h40, 8'hC0, 0);
    run_op(2'd3, 8'h10, 8'h00, 0);
    run_op(2'd3, 8'h60, 8'h20, 0);
    run_op(2'd3, 8'h80, 8'hFF, 0);
    pulse_clr();
    run_op(2'd0, 8'h70, 8'h20, 5);
    repeat (3) @(posedge clk);
    #1;
    check_sticky("idle");
    check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    pulse_clr();

    // Reset while waiting for the raw result abandons the operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 2'd0;
    bus.A = 8'h70;
    bus.B = 8'h20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drive_unit(8'h70, 8'h20);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sticky_ovf_m = 1'b0;
    sticky_dbz_m = 1'b0;
    check("rstw_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rstw_out_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    check_sticky("rstw");

    for (int n = 0; n < 60; n++) begin
      run_op(2'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
             int'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) pulse_clr();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end
endmodule

// File: doc/calc_result_formatter.md
Name: calc_result_formatter

Overview:
- Downstream stage of the fixed-point arithmetic unit.
- Tracks each issued operation across the unit's 1-cycle register latency and selects the requested result (add/sub/mul/div).
- Converts the selected result to the 8-bit Q(7-FRAC).FRAC format with rounding and saturation, and flags overflow and divide-by-zero.
- Presents the formatted result through a valid/ready handshake to the display/output path.

Parameters:
- FRAC, 4, number of fractional bits in the 8-bit operands and result; legal range 1..6.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  operation issued this cycle; A/B also drive the arithmetic unit this cycle
- in_ready  out  1  formatter can accept an operation
- op  in  2  operation: 0 add, 1 sub, 2 mul, 3 div
- A  in  8  signed operand A, same value the arithmetic unit samples
- B  in  8  signed operand B, same value the arithmetic unit samples
- sum_in  in  8  registered sum from the arithmetic unit
- sub_in  in  8  registered difference
- prod_in  in  16  registered product, Q(2·FRAC)
- div_in  in  8  registered truncating integer quotient
- out_valid  out  1  formatted result available
- out_ready  in  1  consumer accepts the result
- result  out  8  signed formatted result
- ovf  out  1  result saturated
- dbz  out  1  division by zero
- ovf_sticky  out  1  sticky overflow (optional feature)
- dbz_sticky  out  1  sticky divide-by-zero (optional feature)
- clr_sticky  in  1  clears the sticky flags (optional feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE and any pending operation is discarded.
  - out_valid, result, ovf, dbz and the sticky flags all go to 0.
  - in_ready is 1 once rst is released.
- FSM IDLE→WAIT→FMT→OUT→IDLE.
  - IDLE: in_ready=1. On in_valid, capture op, A, B and go to WAIT. The capture edge is edge t.
  - WAIT: at edge t+1, capture the raw result selected by op (the arithmetic unit updated at edge t). Go to FMT.
  - FMT: at edge t+2, register result/ovf/dbz and set out_valid=1. Go to OUT.
  - OUT: result, ovf, dbz and out_valid are held stable until out_ready=1. On that edge, out_valid goes to 0 and state returns to IDLE.
- in_ready=0 in every state except IDLE; in_valid presented while in_ready=0 is ignored.
- Latency: out_valid rises after the 2nd rising edge following acceptance. Minimum issue interval is 4 cycles.
- Raw results captured before the first accepted operation are never used; the unit's unreset outputs are don't-care.
- ADD:
  - ovf when A[7]==B[7] and sum_in[7]!=A[7].
  - On ovf, result = A[7] ? 0x80 : 0x7F; otherwise result = sum_in.
- SUB:
  - ovf when A[7]!=B[7] and sub_in[7]!=A[7].
  - Saturation as for ADD; otherwise result = sub_in.
- MUL:
  - Compute (prod_in + 2^(FRAC-1)) in 17-bit signed arithmetic, then arithmetic shift right by FRAC (round half up).
  - If the shifted value is outside [-128,127], saturate toward its sign and set ovf; otherwise result = low 8 bits.
- DIV (integer quotient q = div_in is converted to Q format as q·2^FRAC):
  - If B==0: dbz=1, ovf=0, result = A[7] ? 0x80 : 0x7F.
  - If A==0x80 and B==0xFF: ovf=1, result=0x7F.
  - If q is outside [-2^(7-FRAC), 2^(7-FRAC)-1]: saturate toward the sign of q and set ovf.
  - Otherwise result = q<<FRAC.
- ovf and dbz are valid only while out_valid=1 and are cleared on the FMT edge of the next operation.
- A reset asserted in WAIT, FMT or OUT abandons the operation; no out_valid is produced for it.

Optional Feature:
- Macro: FMT_STICKY_EN.
- Defined:
  - ovf_sticky/dbz_sticky set on any FMT edge that registers ovf/dbz=1.
  - clr_sticky=1 clears them on the next edge.
  - If set and clear occur on the same edge, set wins.
- Undefined: ovf_sticky and dbz_sticky are tied to 0 and clr_sticky is ignored; ports remain present.

Test Plan:
- ADD A=0x30, B=0x20, sum_in=0x50, out_ready=1 → result=0x50, ovf=0, dbz=0; out_valid rises 2 edges after acceptance.
- ADD A=0x70, B=0x20, sum_in=0x90 → result=0x7F, ovf=1; SUB A=0x80, B=0x10, sub_in=0x70 → result=0x80, ovf=1.
- MUL A=0x18, B=0x28, prod_in=0x03C0 → result=0x3C, ovf=0; MUL A=0x40, B=0xC0, prod_in=0xF000 → result=0x80, ovf=1.
- DIV A=0x10, B=0x00 → result=0x7F, dbz=1; DIV A=0x60, B=0x20, div_in=3 → result=0x30; DIV A=0x80, B=0xFF → result=0x7F, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → result/ovf/out_valid stable and in_ready=0 throughout; a second in_valid pulse is ignored; out_ready=1 → in_ready=1 on the next cycle.
- rst low for 1 cycle while in WAIT → out_valid stays 0, in_ready=1 after release. With FMT_STICKY_EN, ovf_sticky stays 1 after the saturating ADD until clr_sticky is pulsed.
